// File: rtl/colorclk_sched_if.sv
// ---------------------------------------------------------------------------
// colorclk_sched_if
// Groups the request handshakes and the generator-facing outputs of the
// colour-clock scheduler.
//   master : requester / generator side (drives requests, observes status)
//   slave  : scheduler side (accepts requests, drives generator controls)
// Signals:
//   req0_valid/req0_mode/req0_ready : core autodetect request (mode 0=PAL 1=NTSC)
//   req1_valid/req1_mode/req1_ready : menu/OSD request, higher priority
//   gen_en, gen_mode                : subcarrier generator enable and mode
//   busy, locked                    : sequence in progress / generator stable
// ---------------------------------------------------------------------------
interface colorclk_sched_if;
  logic req0_valid;
  logic req0_mode;
  logic req0_ready;
  logic req1_valid;
  logic req1_mode;
  logic req1_ready;
  logic gen_en;
  logic gen_mode;
  logic busy;
  logic locked;

  modport master (
    output req0_valid, req0_mode, req1_valid, req1_mode,
    input  req0_ready, req1_ready, gen_en, gen_mode, busy, locked
  );

  modport slave (
    input  req0_valid, req0_mode, req1_valid, req1_mode,
    output req0_ready, req1_ready, gen_en, gen_mode, busy, locked
  );
endinterface

// File: rtl/colorclk_sched.sv
// ---------------------------------------------------------------------------
// colorclk_sched
// Arbitrates and sequences PAL/NTSC switching of the colour-subcarrier
// generator. A switch gates the generator, waits HOLD_CYCLES, changes the
// mode, waits SETTLE_CYCLES, then re-enables it. Port 1 (menu/OSD) has
// priority over port 0 (core autodetect).
// Ports:
//   clk    : generator clock
//   rst_n  : asynchronous active-low reset
//   enable : master colour-clock enable (0 = generator gated)
//   bus    : colorclk_sched_if.slave (request handshakes, gen_en/gen_mode,
//            busy, locked)
// All outputs are registered.
// ---------------------------------------------------------------------------
module colorclk_sched #(
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  colorclk_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, QUIESCE, SWITCH, RESUME} state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mode_q, mode_n;
  logic             gen_en_q, gen_en_n;
  logic             gen_mode_q, gen_mode_n;
  logic             busy_q, busy_n;
  logic             locked_q, locked_n;
  logic             ready0_q, ready0_n;
  logic             ready1_q, ready1_n;

  logic             accept0, accept1, accept_any, accept_mode;

  // A request is accepted when its registered ready coincides with valid.
  // Only one ready can be high at a time, so the accepted mode is unambiguous.
  assign accept0     = bus.req0_valid && ready0_q;
  assign accept1     = bus.req1_valid && ready1_q;
  assign accept_any  = accept0 || accept1;
  assign accept_mode = accept1 ? bus.req1_mode : bus.req0_mode;

  // State and output registers; reset forces the generator gated in PAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= 1'b0;
      gen_en_q   <= 1'b0;
      gen_mode_q <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      ready0_q   <= 1'b0;
      ready1_q   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mode_q     <= mode_n;
      gen_en_q   <= gen_en_n;
      gen_mode_q <= gen_mode_n;
      busy_q     <= busy_n;
      locked_q   <= locked_n;
      ready0_q   <= ready0_n;
      ready1_q   <= ready1_n;
    end
  end

  // Next-state and next-output logic.
  // In IDLE, a running generator that loses enable is gated at once; a gated
  // generator that sees enable goes through the settle-only start sequence.
  // Readys are only offered while IDLE is being held, and never two cycles in
  // a row, so a requester still holding valid after acceptance is not
  // accepted twice.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mode_n     = mode_q;
    gen_en_n   = gen_en_q;
    gen_mode_n = gen_mode_q;
    ready0_n   = 1'b0;
    ready1_n   = 1'b0;

    case (state)
      IDLE: begin
        gen_en_n = gen_en_q && enable;
        if (accept_any && (accept_mode != gen_mode_q) && enable) begin
          mode_n   = accept_mode;
          cnt_n    = HOLD_LOAD;
          gen_en_n = 1'b0;
          state_n  = QUIESCE;
        end else begin
          if (accept_any && (accept_mode != gen_mode_q)) begin
            gen_mode_n = accept_mode;
          end
          if (enable && !gen_en_q) begin
            cnt_n   = SETTLE_LOAD;
            state_n = SWITCH;
          end else if (!ready0_q && !ready1_q) begin
            ready1_n = bus.req1_valid;
            ready0_n = bus.req0_valid && !bus.req1_valid;
          end
        end
      end

      QUIESCE: begin
        gen_en_n = 1'b0;
        if (cnt == '0) begin
          gen_mode_n = mode_q;
          cnt_n      = SETTLE_LOAD;
          state_n    = SWITCH;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      SWITCH: begin
        gen_en_n = 1'b0;
        if (cnt == '0) begin
          state_n = RESUME;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      RESUME: begin
        // Enable may have dropped mid-sequence; in that case stay gated.
        gen_en_n = enable;
        state_n  = IDLE;
      end

      default: begin
        gen_en_n = 1'b0;
        state_n  = IDLE;
      end
    endcase

    locked_n = gen_en_n;
    busy_n   = (state_n != IDLE);
  end

  assign bus.gen_en     = gen_en_q;
  assign bus.gen_mode   = gen_mode_q;
  assign bus.busy       = busy_q;
  assign bus.locked     = locked_q;
  assign bus.req0_ready = ready0_q;
  assign bus.req1_ready = ready1_q;

endmodule
